nco_bank: RTL and testbench
===========================

Name: nco_bank

Overview:
- Multi-channel successor to the single fixed-increment phase accumulator.
- NUM_CH independent phase accumulators, each with a runtime-programmable increment, waveform mode and PWM duty.
- Programmed through a byte-style config port driven from the top-level dedicated inputs; per-channel waveform bits drive uo_out.
- Config updates are double-buffered and commit on the channel's phase wrap, giving glitch-free frequency and duty changes.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- ACC_WIDTH, 16, phase accumulator width per channel.
- INC_WIDTH, 16, increment width; must be <= ACC_WIDTH; zero-extended into the accumulator add.
- DUTY_WIDTH, 8, PWM compare width; must be <= INC_WIDTH and <= ACC_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  1 = accumulators advance; 0 = all accumulators hold
- cfg_valid  in  1  config write request
- cfg_ready  out  1  combinational: ~cfg_busy[cfg_ch]
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_field  in  2  0=increment, 1=duty, 2=mode, 3=phase reset
- cfg_data  in  INC_WIDTH  write data
- cfg_busy  out  NUM_CH  per-channel shadow-pending flag
- wave_out  out  NUM_CH  registered waveform bit per channel
- wrap_out  out  NUM_CH  registered one-cycle pulse when a channel's accumulator wraps

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - acc, active inc, shadow inc, duty and mode: 0 (mode 0 = square).
  - cfg_busy: 0.
  - wave_out and wrap_out: 0.
  - Reset mid-operation discards pending shadow writes.
- Accept: a write is accepted when cfg_valid && cfg_ready at the clock edge. Writes with cfg_ready=0 are dropped with no side effects. cfg_ch >= NUM_CH is always dropped.
- Fields 0 to 2:
  - The write loads the channel shadow register and sets cfg_busy[ch].
  - Shadow inc, duty and mode are separate registers. All three are loaded from their own field only.
  - Mode uses cfg_data[1:0]; duty uses cfg_data[DUTY_WIDTH-1:0].
- Field 3 (phase reset):
  - Clears the channel acc to 0 at that edge and suppresses that cycle's wrap pulse.
  - Does not touch shadows and does not set busy.
- Accumulator per cycle when enable=1: {carry, acc} <= acc + inc. wrap = carry. Modulo 2^ACC_WIDTH wrap-around.
- Commit:
  - Occurs at the edge where the channel's wrap is computed. Shadows are copied to active and busy clears.
  - The new values take effect from the following cycle.
  - If active inc == 0 or enable == 0, commit happens on the first edge after busy is set.
  - A write accepted on the same edge as a wrap does not commit on that wrap. It waits for the next commit opportunity.
- Waveform, registered on the same edge as the acc update, from the new acc value:
  - mode 0 square: acc[ACC_WIDTH-1].
  - mode 1 PWM: acc[ACC_WIDTH-1 -: DUTY_WIDTH] < duty. duty=0 gives constant 0.
  - mode 2 pulse: carry of this cycle's add (rate inc/2^ACC_WIDTH).
  - mode 3: constant 0 (channel muted; acc still runs).
- wrap_out[ch] equals the carry of that cycle, registered. It is 0 while enable=0.
- enable=0: acc holds; wave_out holds its last value, except mode 2, which drives 0.

Optional Feature:
- Macro: NCO_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle when enable=1.
  - LFSR bit ch is added as carry-in to channel ch's accumulator add. This spreads spurs for low increments.
  - Expose lfsr_state out 16 for verification.
- Undefined: carry-in is 0, no LFSR logic exists, and lfsr_state is not present.

Test Plan:
- Reset, write ch0 inc=16'h4000, enable=1:
  - busy[0] clears the next cycle.
  - Then wave_out[0] repeats 0,1,1,0 with period 4 after acc passes 0x4000.
  - wrap_out[0] pulses once per 4 cycles.
- ch1 mode=1, duty=8'h40, inc=16'h0100: wave_out[1] high exactly 64 of every 256 cycles. Then write duty=8'hC0 mid-period: the change appears only after the next wrap_out[1] pulse, with 192/256 high thereafter.
- ch2 inc=16'h2000 running, write inc=16'h8000 with busy[2]=1 pending: the second write is dropped (cfg_ready=0), and the first write commits at the wrap.
- ch3 mode=2, inc=16'h1000: wave_out[3] is a single-cycle pulse every 16 cycles. Set enable=0 for 10 cycles: no pulses and acc frozen. Resume: phase continues from the held value.
- Write accepted on the same edge as a wrap_out pulse: the commit is deferred to the following wrap. Phase reset (field 3) on ch0: acc=0 next cycle and no wrap pulse that cycle.
- Drop rst_n for 1 cycle mid-run with pending writes: all outputs 0, busy=0, and the old shadow is not applied. With NCO_DITHER_EN, lfsr_state=16'hACE1 after reset.

Source files
------------

// File: rtl/nco_bank.sv
`default_nettype none
// ============================================================================
//  Module   : nco_bank
//  Purpose  : Bank of NUM_CH independent numerically controlled oscillators.
//             Each channel owns a phase accumulator with a runtime-programmable
//             increment, waveform mode and PWM duty. Configuration writes land
//             in per-channel shadow registers and are committed to the active
//             set on the channel's phase wrap, so frequency/duty/mode changes
//             never produce a truncated or glitched period.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock
//    rst_n       in   synchronous active-low reset
//    enable      in   1 = accumulators advance, 0 = all accumulators hold
//    cfg_valid   in   config write request
//    cfg_ready   out  combinational, ~cfg_busy[cfg_ch] (0 for absent channel)
//    cfg_ch      in   target channel
//    cfg_field   in   0 = increment, 1 = duty, 2 = mode, 3 = phase reset
//    cfg_data    in   write data
//    cfg_busy    out  per-channel shadow-pending flag
//    wave_out    out  registered waveform bit per channel
//    wrap_out    out  registered one-cycle pulse on accumulator wrap
//    lfsr_state  out  dither LFSR state (only with NCO_DITHER_EN)
//  Build option
//    NCO_DITHER_EN : when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                    seed 16'hACE1) supplies a per-channel carry-in to spread
//                    spurs at low increments. When undefined no LFSR exists.
// ============================================================================
module nco_bank #(
  parameter int NUM_CH     = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int INC_WIDTH  = 16,
  parameter int DUTY_WIDTH = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           enable,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                     cfg_field,
  input  logic [INC_WIDTH-1:0]                           cfg_data,
  output logic [NUM_CH-1:0]                              cfg_busy,
  output logic [NUM_CH-1:0]                              wave_out,
  output logic [NUM_CH-1:0]                              wrap_out
`ifdef NCO_DITHER_EN
  ,
  output logic [15:0]                                    lfsr_state
`endif
);

  localparam int SUM_W = ACC_WIDTH + 1;

  localparam logic [1:0] C_FIELD_INC   = 2'd0;
  localparam logic [1:0] C_FIELD_DUTY  = 2'd1;
  localparam logic [1:0] C_FIELD_MODE  = 2'd2;
  localparam logic [1:0] C_FIELD_PHASE = 2'd3;

  localparam logic [1:0] C_MODE_SQUARE = 2'd0;
  localparam logic [1:0] C_MODE_PWM    = 2'd1;
  localparam logic [1:0] C_MODE_PULSE  = 2'd2;
  localparam logic [1:0] C_MODE_MUTE   = 2'd3;

  // --------------------------------------------------------------------------
  // Config handshake. A channel index beyond NUM_CH matches no channel, so
  // cfg_ready stays low and the write is dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) begin
        cfg_ready = ~cfg_busy[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional dither source
  // --------------------------------------------------------------------------
`ifdef NCO_DITHER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting Fibonacci form: taps 16,14,13,11 map to bits 0,2,3,5.
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_state = lfsr_q;
`endif

  // --------------------------------------------------------------------------
  // Per-channel oscillator
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // active configuration
    logic [ACC_WIDTH-1:0]  acc_q,     acc_d;
    logic [INC_WIDTH-1:0]  inc_q,     inc_d;
    logic [DUTY_WIDTH-1:0] duty_q,    duty_d;
    logic [1:0]            mode_q,    mode_d;
    // shadow configuration
    logic [INC_WIDTH-1:0]  sh_inc_q,  sh_inc_d;
    logic [DUTY_WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [1:0]            sh_mode_q, sh_mode_d;
    // status / outputs
    logic                  busy_q,    busy_d;
    logic                  wave_q,    wave_d;
    logic                  wrap_q,    wrap_d;

    logic                  w_hit;
    logic                  w_wr_shadow;
    logic                  w_phase_rst;
    logic                  w_cin;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_wrap;
    logic                  w_commit;
    logic                  w_wave_new;

    assign w_hit = cfg_valid && cfg_ready && (int'(cfg_ch) == g);

`ifdef NCO_DITHER_EN
    assign w_cin = lfsr_q[g];
`else
    assign w_cin = 1'b0;
`endif

    always_comb begin
      w_wr_shadow = w_hit && (cfg_field != C_FIELD_PHASE);
      w_phase_rst = w_hit && (cfg_field == C_FIELD_PHASE);

      w_sum  = {1'b0, acc_q} + SUM_W'(inc_q) + SUM_W'(w_cin);
      // A phase reset overrides the add, so its carry must not be reported.
      w_wrap = enable && w_sum[ACC_WIDTH] && !w_phase_rst;

      // Commit needs a pending shadow from an earlier edge (busy_q). With a
      // zero increment or a halted bank the wrap would never come, so commit
      // on the first opportunity instead.
      w_commit = busy_q && (w_wrap || (inc_q == '0) || !enable);

      // accumulator
      acc_d = acc_q;
      if (w_phase_rst) begin
        acc_d = '0;
      end else if (enable) begin
        acc_d = w_sum[ACC_WIDTH-1:0];
      end

      // shadows, each loaded only by its own field
      sh_inc_d  = sh_inc_q;
      sh_duty_d = sh_duty_q;
      sh_mode_d = sh_mode_q;
      if (w_wr_shadow) begin
        case (cfg_field)
          C_FIELD_INC:  sh_inc_d  = cfg_data;
          C_FIELD_DUTY: sh_duty_d = cfg_data[DUTY_WIDTH-1:0];
          C_FIELD_MODE: sh_mode_d = cfg_data[1:0];
          default:      sh_inc_d  = sh_inc_q;
        endcase
      end

      // A write never coincides with a commit on the same channel because
      // writes are only accepted while busy_q is low.
      busy_d = busy_q;
      if (w_commit) begin
        busy_d = 1'b0;
      end
      if (w_wr_shadow) begin
        busy_d = 1'b1;
      end

      inc_d  = inc_q;
      duty_d = duty_q;
      mode_d = mode_q;
      if (w_commit) begin
        inc_d  = sh_inc_q;
        duty_d = sh_duty_q;
        mode_d = sh_mode_q;
      end

      // waveform from the post-update accumulator, using the mode/duty that
      // were active during this cycle
      case (mode_q)
        C_MODE_SQUARE: w_wave_new = acc_d[ACC_WIDTH-1];
        C_MODE_PWM:    w_wave_new = (acc_d[ACC_WIDTH-1 -: DUTY_WIDTH] < duty_q);
        C_MODE_PULSE:  w_wave_new = w_wrap;
        C_MODE_MUTE:   w_wave_new = 1'b0;
        default:       w_wave_new = 1'b0;
      endcase

      if (enable || w_phase_rst) begin
        wave_d = w_wave_new;
      end else if (mode_q == C_MODE_PULSE) begin
        wave_d = 1'b0;
      end else begin
        wave_d = wave_q;
      end

      wrap_d = w_wrap;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q     <= '0;
        inc_q     <= '0;
        duty_q    <= '0;
        mode_q    <= C_MODE_SQUARE;
        sh_inc_q  <= '0;
        sh_duty_q <= '0;
        sh_mode_q <= C_MODE_SQUARE;
        busy_q    <= 1'b0;
        wave_q    <= 1'b0;
        wrap_q    <= 1'b0;
      end else begin
        acc_q     <= acc_d;
        inc_q     <= inc_d;
        duty_q    <= duty_d;
        mode_q    <= mode_d;
        sh_inc_q  <= sh_inc_d;
        sh_duty_q <= sh_duty_d;
        sh_mode_q <= sh_mode_d;
        busy_q    <= busy_d;
        wave_q    <= wave_d;
        wrap_q    <= wrap_d;
      end
    end

    assign cfg_busy[g] = busy_q;
    assign wave_out[g] = wave_q;
    assign wrap_out[g] = wrap_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nco_bank
//  Purpose  : Self-checking bench for nco_bank (NUM_CH=4, 16-bit phase).
//             A vector table walks channel 0 through increment programming,
//             phase reset, mute mode and deferred commit; hand-written
//             sequences cover PWM duty, dropped writes, pulse mode with
//             enable gating and reset with pending writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nco_bank;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch    = 2'd0;
  logic [1:0]  cfg_field = 2'd0;
  logic [15:0] cfg_data  = 16'd0;
  logic        cfg_ready;
  logic [3:0]  cfg_busy;
  logic [3:0]  wave_out;
  logic [3:0]  wrap_out;
`ifdef NCO_DITHER_EN
  logic [15:0] lfsr_state;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nco_bank #(
    .NUM_CH     (4),
    .ACC_WIDTH  (16),
    .INC_WIDTH  (16),
    .DUTY_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .cfg_busy   (cfg_busy),
    .wave_out   (wave_out),
    .wrap_out   (wrap_out)
`ifdef NCO_DITHER_EN
    ,
    .lfsr_state (lfsr_state)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  f;
    logic [15:0] d;
    logic        rdy;
    logic [3:0]  busy;
    logic [3:0]  wave;
    logic [3:0]  wrap;
  } vec_t;

  vec_t tbl [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] field, input logic [15:0] data);
    cfg_ch    = ch;
    cfg_field = field;
    cfg_data  = data;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Advance until wrap_out[ch] is seen; n = ticks taken.
  task automatic wait_wrap(input int ch, input int budget, output int n, output bit hit);
    n   = 0;
    hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      n++;
      if (wrap_out[ch]) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  hit;
    int  hi;
    int  wr;
    int  mism;

    //            v     f     d         rdy   busy     wave     wrap
    tbl[0]  = '{1'b1, 2'd0, 16'h4000, 1'b1, 4'b0001, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    tbl[4]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    tbl[5]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
    tbl[6]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    tbl[8]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    tbl[9]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
    tbl[10] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[11] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    tbl[12] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    // phase reset exactly where the add would have wrapped
    tbl[13] = '{1'b1, 2'd3, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[14] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[15] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};
    // mode 3 (mute), committed on the next wrap
    tbl[16] = '{1'b1, 2'd2, 16'h0003, 1'b1, 4'b0001, 4'b0001, 4'b0000};
    tbl[17] = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 4'b0001};
    tbl[18] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[20] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[21] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0001};
    tbl[22] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[23] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[24] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    // mode 0 written on a wrap edge: deferred a full period
    tbl[25] = '{1'b1, 2'd2, 16'h0000, 1'b1, 4'b0001, 4'b0000, 4'b0001};
    tbl[26] = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'b0001, 4'b0000, 4'b0000};
    tbl[27] = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'b0001, 4'b0000, 4'b0000};
    tbl[28] = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'b0001, 4'b0000, 4'b0000};
    tbl[29] = '{1'b0, 2'd0, 16'h0000, 1'b0, 4'b0000, 4'b0000, 4'b0001};
    tbl[30] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'b0000};
    tbl[31] = '{1'b0, 2'd0, 16'h0000, 1'b1, 4'b0000, 4'b0001, 4'b0000};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    tick();
    tick();
    check("reset busy", cfg_busy, 4'b0000);
    check("reset wave", wave_out, 4'b0000);
    check("reset wrap", wrap_out, 4'b0000);
    check("reset ready", cfg_ready, 1'b1);
`ifdef NCO_DITHER_EN
    check("reset lfsr", lfsr_state, 16'hACE1);
`endif
    rst_n = 1'b1;

    // ---------------- vector table on channel 0 ----------------
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cfg_ch    = 2'd0;
      cfg_valid = tbl[i].v;
      cfg_field = tbl[i].f;
      cfg_data  = tbl[i].d;
      #1;
      check($sformatf("v%0d ready", i), cfg_ready, tbl[i].rdy);
      tick();
      cfg_valid = 1'b0;
      check($sformatf("v%0d busy", i), cfg_busy, tbl[i].busy);
      check($sformatf("v%0d wave", i), wave_out, tbl[i].wave);
      check($sformatf("v%0d wrap", i), wrap_out, tbl[i].wrap);
    end

    // ---------------- ch1 PWM ----------------
    do_reset();
    enable = 1'b1;
    cfg_write(2'd1, 2'd2, 16'h0001);
    check("pwm mode busy set", cfg_busy[1], 1'b1);
    tick();
    check("pwm mode busy clear", cfg_busy[1], 1'b0);
    cfg_write(2'd1, 2'd1, 16'h0040);
    tick();
    cfg_write(2'd1, 2'd0, 16'h0100);
    tick();
    hi = 0;
    wr = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      hi += int'(wave_out[1]);
      wr += int'(wrap_out[1]);
    end
    check("pwm 0x40 high count", hi, 64);
    check("pwm wrap count", wr, 1);

    wait_wrap(1, 300, n, hit);
    check("pwm wrap seen", hit, 1'b1);
    for (int k = 0; k < 100; k++) tick();
    cfg_write(2'd1, 2'd1, 16'h00C0);
    check("pwm duty busy", cfg_busy[1], 1'b1);
    hi = int'(wave_out[1]);
    hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (wrap_out[1]) begin
        hit = 1'b1;
        break;
      end
      hi += int'(wave_out[1]);
    end
    check("pwm second wrap seen", hit, 1'b1);
    check("pwm old duty before wrap", hi, 0);
    check("pwm duty committed", cfg_busy[1], 1'b0);
    hi = int'(wave_out[1]);
    for (int k = 0; k < 255; k++) begin
      tick();
      hi += int'(wave_out[1]);
    end
    check("pwm 0xC0 high count", hi, 192);

    // ---------------- ch2 dropped write while busy ----------------
    cfg_write(2'd2, 2'd0, 16'h2000);
    tick();
    wait_wrap(2, 20, n, hit);
    check("ch2 wrap seen", hit, 1'b1);
    tick();
    tick();
    cfg_write(2'd2, 2'd0, 16'h1000);
    check("ch2 pending", cfg_busy[2], 1'b1);
    cfg_ch    = 2'd2;
    cfg_field = 2'd0;
    cfg_data  = 16'h8000;
    cfg_valid = 1'b1;
    #1;
    check("ch2 ready while busy", cfg_ready, 1'b0);
    tick();
    cfg_valid = 1'b0;
    check("ch2 still pending", cfg_busy[2], 1'b1);
    wait_wrap(2, 20, n, hit);
    check("ch2 commit wrap seen", hit, 1'b1);
    check("ch2 busy after wrap", cfg_busy[2], 1'b0);
    wait_wrap(2, 40, n, hit);
    check("ch2 period after commit", n, 16);

    // ---------------- ch3 pulse mode with enable gating ----------------
    cfg_write(2'd3, 2'd2, 16'h0002);
    tick();
    cfg_write(2'd3, 2'd0, 16'h1000);
    tick();
    wait_wrap(3, 40, n, hit);
    check("ch3 wrap seen", hit, 1'b1);
    hi   = 0;
    mism = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      hi += int'(wave_out[3]);
      if (wave_out[3] !== wrap_out[3]) mism++;
    end
    check("ch3 pulses in 32", hi, 2);
    check("ch3 pulse equals wrap", mism, 0);
    for (int k = 0; k < 5; k++) tick();
    enable = 1'b0;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      hi += int'(wave_out[3]) + int'(wrap_out[3]);
    end
    check("ch3 quiet while disabled", hi, 0);
    enable = 1'b1;
    wait_wrap(3, 30, n, hit);
    check("ch3 phase held", n, 11);

    // ---------------- reset with pending writes ----------------
    wait_wrap(2, 40, n, hit);
    cfg_write(2'd2, 2'd0, 16'h4000);
    check("rst pending ch2", cfg_busy[2], 1'b1);
    cfg_write(2'd1, 2'd1, 16'h0010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst busy", cfg_busy, 4'b0000);
    check("midrst wave", wave_out, 4'b0000);
    check("midrst wrap", wrap_out, 4'b0000);
    cfg_ch = 2'd2;
    #1;
    check("midrst ready", cfg_ready, 1'b1);
`ifdef NCO_DITHER_EN
    check("midrst lfsr", lfsr_state, 16'hACE1);
`endif
    hi = 0;
    wr = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      hi += int'(wave_out != 4'b0000);
      wr += int'(wrap_out != 4'b0000) + int'(cfg_busy != 4'b0000);
    end
    check("post-rst wave quiet", hi, 0);
    check("post-rst no wrap/busy", wr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
